// File: rtl/pid_multi_pkg.sv
// Shared types and constants for the multi-channel PID sweep controller:
// FSM state encoding, CSR word addresses, Q8.8 gain type and the PWM clamp.
package pid_multi_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RD_REQ    = 3'd1;
  localparam state_t ST_RD_WAIT   = 3'd2;
  localparam state_t ST_CALC      = 3'd3;
  localparam state_t ST_CALC_WAIT = 3'd4;
  localparam state_t ST_WR_REQ    = 3'd5;
  localparam state_t ST_NEXT      = 3'd6;

  localparam logic [4:0] CSR_CTRL     = 5'd0;
  localparam logic [4:0] CSR_STATUS   = 5'd1;
  localparam logic [4:0] CSR_KP       = 5'd2;
  localparam logic [4:0] CSR_KI       = 5'd3;
  localparam logic [4:0] CSR_KD       = 5'd4;
  localparam logic [4:0] CSR_SETPOINT = 5'd16;

  typedef logic signed [15:0] gain_q88_t;

  // Signed clamp into [0, max_val]; result is a zero-extended PWM word.
  function automatic logic [31:0] clamp_pwm(input logic signed [31:0] v,
                                            input logic [31:0] max_val);
    logic [31:0] r;
    if (v < 0)
      r = '0;
    else if (v > $signed(max_val))
      r = max_val;
    else
      r = v;
    return r;
  endfunction

endpackage

// File: rtl/pid_core.sv
// Per-channel PID datapath: stage 1 forms error/integrator/derivative and
// updates the channel's state, stage 2 forms the Q8.8 weighted sum; 2-cycle latency.
module pid_core
  import pid_multi_pkg::*;
#(
  parameter int CH_W   = 2,
  parameter int TEMP_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CH_W-1:0]   ch,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic [TEMP_W-1:0] sample,
  input  logic [15:0]       kp,
  input  logic [15:0]       ki,
  input  logic [15:0]       kd,
  output logic [OUT_W-1:0]  control
);
  localparam int CH_N = 1 << CH_W;
  localparam int E_W  = TEMP_W + 2;
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OUT_W - 1));

  logic signed [OUT_W-1:0] integ_q [CH_N];
  logic signed [OUT_W-1:0] integ_d [CH_N];
  logic signed [E_W-1:0]   prev_q  [CH_N];
  logic signed [E_W-1:0]   prev_d  [CH_N];
  logic                    s1_vld_q, s1_vld_d;
  logic signed [E_W-1:0]   err_q, err_d, deriv_q, deriv_d;
  logic signed [OUT_W-1:0] integ_s1_q, integ_s1_d;
  gain_q88_t               kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [OUT_W-1:0] control_q, control_d;
  logic signed [TEMP_W-1:0] sp_s, smp_s;
  logic signed [E_W-1:0]   err;
  logic signed [63:0]      integ_sum, acc;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [63:0] v);
    logic signed [63:0] r;
    r = v;
    if (v > OUT_MAX)
      r = OUT_MAX;
    else if (v < OUT_MIN)
      r = OUT_MIN;
    return r[OUT_W-1:0];
  endfunction

  always_comb begin
    sp_s       = setpoint;
    smp_s      = sample;
    err        = E_W'(sp_s) - E_W'(smp_s);
    integ_sum  = 64'(integ_q[ch]) + 64'(err);
    integ_d    = integ_q;
    prev_d     = prev_q;
    s1_vld_d   = en;
    err_d      = err_q;
    deriv_d    = deriv_q;
    integ_s1_d = integ_s1_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    // Gains are sampled with the operands so a CSR write mid-sweep lands cleanly.
    if (en) begin
      err_d       = err;
      deriv_d     = err - prev_q[ch];
      integ_s1_d  = sat_out(integ_sum);
      integ_d[ch] = sat_out(integ_sum);
      prev_d[ch]  = err;
      kp_d        = kp;
      ki_d        = ki;
      kd_d        = kd;
    end
    acc = 64'(kp_q) * 64'(err_q) + 64'(ki_q) * 64'(integ_s1_q) + 64'(kd_q) * 64'(deriv_q);
    control_d = s1_vld_q ? sat_out(acc >>> 8) : control_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH_N; i++) begin
        integ_q[i] <= '0;
        prev_q[i]  <= '0;
      end
      s1_vld_q   <= 1'b0;
      err_q      <= '0;
      deriv_q    <= '0;
      integ_s1_q <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      control_q  <= '0;
    end else begin
      integ_q    <= integ_d;
      prev_q     <= prev_d;
      s1_vld_q   <= s1_vld_d;
      err_q      <= err_d;
      deriv_q    <= deriv_d;
      integ_s1_q <= integ_s1_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      control_q  <= control_d;
    end
  end

  assign control = control_q;

endmodule

// File: rtl/pid_multi_control.sv
// Sweeps CHANNELS sensors over Avalon-MM, runs one PID step per channel and writes
// the clamped result to the matching PWM slave. PID_MULTI_TIMEOUT_EN adds a read timeout.
module pid_multi_control
  import pid_multi_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          TEMP_W      = 8,
  parameter int          OUT_W       = 16,
  parameter int          PWM_MAX     = 4095,
  parameter logic [15:0] SENSOR_BASE = 16'h0000,
  parameter logic [15:0] PWM_BASE    = 16'h0000,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] temp_address,
  output logic        temp_read,
  input  logic [31:0] temp_readdata,
  input  logic        temp_readdatavalid,
  input  logic        temp_waitrequest,
  output logic [15:0] pwm_address,
  output logic        pwm_write,
  output logic [31:0] pwm_writedata,
  input  logic        pwm_waitrequest,
  input  logic [4:0]  csr_address,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CH_N = 1 << CH_W;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              cw_q, cw_d;
  logic              run_q, run_d;
  logic              sts_to_q, sts_to_d;
  logic [3:0]        sts_ch_q, sts_ch_d;
  logic [15:0]       kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [TEMP_W-1:0] sp_q [CH_N];
  logic [TEMP_W-1:0] sp_d [CH_N];
  logic [TEMP_W-1:0] sample_q, sample_d;
  logic [31:0]       csr_readdata_q, csr_readdata_d;
  logic [4:0]        sp_off;
  logic [CH_W-1:0]   sp_idx;
  logic              sp_hit;
  logic              pid_en;
  logic [OUT_W-1:0]  control;
  logic              unused_bits;
`ifdef PID_MULTI_TIMEOUT_EN
  logic [31:0]       wait_cnt_q, wait_cnt_d;
`endif

  assign sp_off = csr_address - CSR_SETPOINT;
  assign sp_idx = sp_off[CH_W-1:0];
  assign sp_hit = (csr_address >= CSR_SETPOINT) && ({27'd0, sp_off} < 32'(CHANNELS));
  assign unused_bits = ^{temp_readdata[31:TEMP_W], csr_writedata[31:16]};

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    cw_d           = cw_q;
    run_d          = run_q;
    sts_to_d       = sts_to_q;
    sts_ch_d       = sts_ch_q;
    kp_d           = kp_q;
    ki_d           = ki_q;
    kd_d           = kd_q;
    sp_d           = sp_q;
    sample_d       = sample_q;
    csr_readdata_d = '0;
`ifdef PID_MULTI_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
`endif

    if (csr_write) begin
      case (csr_address)
        CSR_CTRL: begin
          run_d = csr_writedata[0];
          if (csr_writedata[1]) begin
            sts_to_d = 1'b0;
            sts_ch_d = '0;
          end
        end
        CSR_KP:  kp_d = csr_writedata[15:0];
        CSR_KI:  ki_d = csr_writedata[15:0];
        CSR_KD:  kd_d = csr_writedata[15:0];
        default: if (sp_hit) sp_d[sp_idx] = csr_writedata[TEMP_W-1:0];
      endcase
    end

    if (csr_read) begin
      case (csr_address)
        CSR_CTRL:   csr_readdata_d = {31'd0, run_q};
        CSR_STATUS: csr_readdata_d = {24'd0, sts_ch_q, 3'd0, sts_to_q};
        CSR_KP:     csr_readdata_d = {16'd0, kp_q};
        CSR_KI:     csr_readdata_d = {16'd0, ki_q};
        CSR_KD:     csr_readdata_d = {16'd0, kd_q};
        default:    if (sp_hit) csr_readdata_d = 32'($signed(sp_q[sp_idx]));
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        ch_d = '0;
        if (run_q) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
`ifdef PID_MULTI_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (!temp_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (temp_readdatavalid) begin
          sample_d = temp_readdata[TEMP_W-1:0];
          state_d  = ST_CALC;
        end
`ifdef PID_MULTI_TIMEOUT_EN
        // A timed-out channel is skipped entirely so its PID history is untouched.
        else if (wait_cnt_q == 32'(TIMEOUT - 1)) begin
          sts_to_d = 1'b1;
          sts_ch_d = 4'(ch_q);
          state_d  = ST_NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
`endif
      end
      ST_CALC: begin
        cw_d    = 1'b0;
        state_d = ST_CALC_WAIT;
      end
      ST_CALC_WAIT: begin
        cw_d = 1'b1;
        if (cw_q) state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (!pwm_waitrequest) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        if (run_q) begin
          state_d = ST_RD_REQ;
        end else begin
          ch_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      cw_q           <= 1'b0;
      run_q          <= 1'b0;
      sts_to_q       <= 1'b0;
      sts_ch_q       <= '0;
      kp_q           <= '0;
      ki_q           <= '0;
      kd_q           <= '0;
      for (int i = 0; i < CH_N; i++) sp_q[i] <= '0;
      sample_q       <= '0;
      csr_readdata_q <= '0;
`ifdef PID_MULTI_TIMEOUT_EN
      wait_cnt_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      cw_q           <= cw_d;
      run_q          <= run_d;
      sts_to_q       <= sts_to_d;
      sts_ch_q       <= sts_ch_d;
      kp_q           <= kp_d;
      ki_q           <= ki_d;
      kd_q           <= kd_d;
      sp_q           <= sp_d;
      sample_q       <= sample_d;
      csr_readdata_q <= csr_readdata_d;
`ifdef PID_MULTI_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
`endif
    end
  end

  assign pid_en = (state_q == ST_CALC);

  pid_core #(
    .CH_W  (CH_W),
    .TEMP_W(TEMP_W),
    .OUT_W (OUT_W)
  ) u_pid_core (
    .clk     (clk),
    .reset   (reset),
    .en      (pid_en),
    .ch      (ch_q),
    .setpoint(sp_q[ch_q]),
    .sample  (sample_q),
    .kp      (kp_q),
    .ki      (ki_q),
    .kd      (kd_q),
    .control (control)
  );

  // Strobes decode straight from the state flop so an async reset drops them at once.
  assign temp_read     = (state_q == ST_RD_REQ);
  assign temp_address  = temp_read ? SENSOR_BASE + 16'(ch_q) : 16'd0;
  assign pwm_write     = (state_q == ST_WR_REQ);
  assign pwm_address   = pwm_write ? PWM_BASE + 16'(ch_q) : 16'd0;
  assign pwm_writedata = pwm_write ? clamp_pwm(32'($signed(control)), 32'(PWM_MAX)) : 32'd0;
  assign csr_readdata  = csr_readdata_q;

endmodule
